// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: splits byte/halfword/word accesses into byte-wide memory cycles.
// Optional `LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word requests instead of splitting them.
module lsu_byte_sequencer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              n_Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_wd,
  input  logic [7:0]        mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_buf;

  logic        illegal_c;
  logic [1:0]  last_c;
  logic [31:0] ld_raw_c;
  logic [31:0] ld_ext_c;

  // Request legality, evaluated on the incoming request at the acceptance edge
  always_comb begin
    illegal_c = (req_size == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_size == 2'b01 && req_addr[0]) illegal_c = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) illegal_c = 1'b1;
`endif
  end

  // Index of the final byte, plus the load word with the byte arriving this cycle merged in
  always_comb begin
    case (size_q)
      2'b00:   last_c = 2'd0;
      2'b01:   last_c = 2'd1;
      default: last_c = 2'd3;
    endcase
    ld_raw_c = ld_buf;
    ld_raw_c[{cnt, 3'b000} +: 8] = mem_rd;
    case (size_q)
      2'b00:   ld_ext_c = uns_q ? {24'h0, ld_raw_c[7:0]}  : {{24{ld_raw_c[7]}}, ld_raw_c[7:0]};
      2'b01:   ld_ext_c = uns_q ? {16'h0, ld_raw_c[15:0]} : {{16{ld_raw_c[15]}}, ld_raw_c[15:0]};
      default: ld_ext_c = ld_raw_c;
    endcase
  end

  // Memory-port outputs are registered one step ahead so each ACCESS cycle presents its own byte
  always_ff @(posedge Clk or negedge n_Rst) begin
    if (!n_Rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= 32'h0;
      ld_buf    <= 32'h0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_wd    <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            size_q    <= req_size;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            ld_buf    <= 32'h0;
            cnt       <= 2'd0;
            if (illegal_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              wdata_q   <= 32'h0;
            end else begin
              state   <= ACCESS;
              mem_a   <= req_addr;
              mem_we  <= req_we;
              mem_wd  <= req_we ? req_wdata[7:0] : 8'h0;
              wdata_q <= req_wdata >> 8;
            end
          end
        end
        ACCESS: begin
          if (!we_q) ld_buf <= ld_raw_c;
          if (cnt == last_c) begin
            state     <= RESP;
            mem_we    <= 1'b0;
            mem_wd    <= 8'h0;
            mem_a     <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? 32'h0 : ld_ext_c;
          end else begin
            cnt     <= cnt + 2'd1;
            mem_a   <= mem_a + ADDR_W'(1);
            mem_wd  <= we_q ? wdata_q[7:0] : 8'h0;
            wdata_q <= wdata_q >> 8;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: byte-array memory, reference memory model and per-cycle output compare.
module tb_lsu_byte_sequencer;

  localparam int unsigned AW = 8;

  logic          Clk = 1'b0;
  logic          n_Rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_wd, mem_rd;

  lsu_byte_sequencer #(.ADDR_W(AW)) dut (
    .Clk(Clk), .n_Rst(n_Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 Clk = ~Clk;

  // Byte memory seen by the DUT, and the bench's own view of what it should hold
  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];
  assign mem_rd = tb_mem[mem_a];
  always @(posedge Clk) if (mem_we) tb_mem[mem_a] <= mem_wd;

  typedef struct {
    logic        rdy, vld, err, we, chk_a, chk_wd;
    logic [7:0]  a, wd;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: next queued expectation, or idle outputs when nothing is in flight
  always @(negedge Clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '{rdy: 1'b1, vld: 1'b0, err: 1'b0, we: 1'b0, chk_a: 1'b0,
                   chk_wd: 1'b1, a: 8'h0, wd: 8'h0, rd: 32'h0};
      chk("req_ready", 32'(req_ready), 32'(cur.rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(cur.vld));
      chk("mem_we", 32'(mem_we), 32'(cur.we));
      if (cur.chk_a)  chk("mem_a", 32'(mem_a), 32'(cur.a));
      if (cur.chk_wd) chk("mem_wd", 32'(mem_wd), 32'(cur.wd));
      if (cur.vld) begin
        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
        chk("rsp_rdata", rsp_rdata, cur.rd);
      end
      if (rsp_valid) begin
        last_rd  = rsp_rdata;
        last_err = rsp_err;
      end
    end
  end

  function automatic bit is_illegal(input logic [1:0] size, input logic [7:0] addr);
    bit ill = (size == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    if (size == 2'b01 && addr[0] != 1'b0) ill = 1;
    if (size == 2'b10 && addr[1:0] != 2'b00) ill = 1;
`endif
    return ill;
  endfunction

  // Reference behaviour of one accepted request, queued as per-cycle expectations
  task automatic model_push(input logic we, input logic [1:0] size, input logic uns,
                            input logic [7:0] addr, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    exp_t e;
    if (is_illegal(size, addr)) begin
      exp_q.push_back('{rdy: 1'b0, vld: 1'b1, err: 1'b1, we: 1'b0, chk_a: 1'b0,
                        chk_wd: 1'b1, a: 8'h0, wd: 8'h0, rd: 32'h0});
      return;
    end
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    v = 32'h0;
    for (int j = 0; j < n; j++) begin
      e = '{rdy: 1'b0, vld: 1'b0, err: 1'b0, we: we, chk_a: 1'b1, chk_wd: we,
            a: 8'(addr + j), wd: we ? 8'(wd >> (8 * j)) : 8'h0, rd: 32'h0};
      exp_q.push_back(e);
      v = v | (32'(ref_mem[8'(addr + j)]) << (8 * j));
      if (we) ref_mem[8'(addr + j)] = 8'(wd >> (8 * j));
    end
    if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    exp_q.push_back('{rdy: 1'b0, vld: 1'b1, err: 1'b0, we: 1'b0, chk_a: 1'b0,
                      chk_wd: 1'b1, a: 8'h0, wd: 8'h0, rd: we ? 32'h0 : v});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge Clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  // Issue one request; 'noise' keeps req_valid high with junk fields while busy
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wd, input bit noise);
    wait_drain();
    @(negedge Clk); #1;
    last_rd = 32'h5A5A5A5A; last_err = 1'bx;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge Clk); #1;
    model_push(we, size, uns, addr, wd);
    if (noise) begin
      req_we = 1'b1; req_size = 2'(($urandom % 3)); req_addr = 8'($urandom);
      req_wdata = $urandom;
    end else req_valid = 1'b0;
    wait_drain();
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin tb_mem[i] = 8'h0; ref_mem[i] = 8'h0; end
    n_Rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_mem_wd", 32'(mem_wd), 32'h0);
    @(negedge Clk); n_Rst = 1'b1; chk_en = 1;

    run_req(1, 2'b10, 0, 8'h10, 32'hDEADBEEF, 0);
    chk("st_word_err", 32'(last_err), 32'h0);
    chk("st_word_bytes", {tb_mem[8'h13], tb_mem[8'h12], tb_mem[8'h11], tb_mem[8'h10]}, 32'hDEADBEEF);
    run_req(0, 2'b10, 0, 8'h10, 32'h0, 0);
    chk("ld_word", last_rd, 32'hDEADBEEF);
    run_req(0, 2'b00, 0, 8'h13, 32'h0, 0);
    chk("ld_byte_s", last_rd, 32'hFFFFFFDE);
    run_req(0, 2'b00, 1, 8'h13, 32'h0, 0);
    chk("ld_byte_u", last_rd, 32'h000000DE);
    run_req(0, 2'b01, 0, 8'h12, 32'h0, 0);
    chk("ld_half_s", last_rd, 32'hFFFFDEAD);
    run_req(0, 2'b01, 1, 8'h12, 32'h0, 0);
    chk("ld_half_u", last_rd, 32'h0000DEAD);

    run_req(0, 2'b10, 0, 8'h11, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("misalign_err", 32'(last_err), 32'h1);
    chk("misalign_rdata", last_rd, 32'h0);
`else
    chk("misalign_err", 32'(last_err), 32'h0);
    chk("misalign_rdata", last_rd, 32'h00DEADBE);
`endif

    run_req(1, 2'b10, 0, 8'hFE, 32'h12345678, 0);
    chk("wrap_bytes", {tb_mem[8'h01], tb_mem[8'h00], tb_mem[8'hFF], tb_mem[8'hFE]}, 32'h12345678);
    run_req(0, 2'b10, 0, 8'hFE, 32'h0, 0);
    chk("wrap_load", last_rd, 32'h12345678);

    run_req(1, 2'b11, 0, 8'h20, 32'hFFFFFFFF, 0);
    chk("illegal_err", 32'(last_err), 32'h1);
    chk("illegal_nowrite", 32'(tb_mem[8'h20]), 32'h0);

    run_req(1, 2'b00, 0, 8'h30, 32'h777777A5, 0);
    run_req(1, 2'b01, 0, 8'h32, 32'h99998001, 0);
    run_req(0, 2'b01, 0, 8'h32, 32'h0, 0);
    chk("ld_half_neg", last_rd, 32'hFFFF8001);
    run_req(0, 2'b00, 0, 8'h30, 32'h0, 1);
    chk("ld_byte_noise", last_rd, 32'hFFFFFFA5);
    run_req(0, 2'b10, 1, 8'h10, 32'h0, 1);
    chk("ld_word_noise", last_rd, 32'hDEADBEEF);

    // Reset after the second byte of a word store
    wait_drain();
    @(negedge Clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 8'h40; req_wdata = 32'hCAFEF00D;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    exp_q.push_back('{rdy: 1'b0, vld: 1'b0, err: 1'b0, we: 1'b1, chk_a: 1'b1,
                      chk_wd: 1'b1, a: 8'h40, wd: 8'h0D, rd: 32'h0});
    exp_q.push_back('{rdy: 1'b0, vld: 1'b0, err: 1'b0, we: 1'b1, chk_a: 1'b1,
                      chk_wd: 1'b1, a: 8'h41, wd: 8'hF0, rd: 32'h0});
    ref_mem[8'h40] = 8'h0D; ref_mem[8'h41] = 8'hF0;
    wait_drain();
    @(posedge Clk); #1;
    n_Rst = 1'b0; #1;
    chk("midrst_req_ready", 32'(req_ready), 32'h1);
    chk("midrst_mem_we", 32'(mem_we), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge Clk); #1;
    n_Rst = 1'b1;
    chk("midrst_bytes", {tb_mem[8'h43], tb_mem[8'h42], tb_mem[8'h41], tb_mem[8'h40]}, 32'h0000F00D);
    run_req(0, 2'b10, 0, 8'h40, 32'h0, 0);
    chk("post_rst_load", last_rd, 32'h0000F00D);
    run_req(1, 2'b01, 0, 8'h44, 32'h0000BEEF, 0);
    chk("post_rst_store", {tb_mem[8'h45], tb_mem[8'h44]}, 32'h0000BEEF);

    wait_drain();
    @(negedge Clk); #1;
    begin
      int mism = 0;
      for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
      chk("mem_image", 32'(mism), 32'h0);
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
